// File: rtl/al_pkg.sv
// Shared constants and BCD helpers for the alarm timekeeper.
package al_pkg;

    localparam logic [7:0] BCD_00 = 8'h00;
    localparam logic [7:0] BCD_01 = 8'h01;
    localparam logic [7:0] BCD_11 = 8'h11;
    localparam logic [7:0] BCD_12 = 8'h12;
    localparam logic [7:0] BCD_23 = 8'h23;
    localparam logic [7:0] BCD_59 = 8'h59;

    localparam int AL_MODE_12H = 0;
    localparam int AL_MODE_24H = 1;

    localparam int SNOOZE_MIN_LO  = 1;
    localparam int SNOOZE_MIN_HI  = 59;
    localparam int TIMEOUT_MIN_LO = 1;
    localparam int TIMEOUT_MIN_HI = 59;

    // Keep out-of-range parameters inside the legal window.
    function automatic int clamp_rng(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic logic [7:0] bcd_inc(logic [7:0] b);
        if (b[3:0] == 4'd9) return {b[7:4] + 4'd1, 4'd0};
        else                return {b[7:4], b[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] bcd2bin(logic [7:0] b);
        return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    endfunction

    function automatic logic [7:0] bin2bcd(logic [6:0] v);
        logic [6:0] t;
        logic [6:0] u;
        t = v / 7'd10;
        u = v - t * 7'd10;
        return {t[3:0], u[3:0]};
    endfunction

    // One hour step; returns {pm, hh}. 11->12 toggles pm in 12h mode.
    function automatic logic [8:0] hr_inc(logic [7:0] h, logic p, logic m24);
        if (m24)               return {1'b0, (h == BCD_23) ? BCD_00 : bcd_inc(h)};
        else if (h == BCD_12)  return {p, BCD_01};
        else if (h == BCD_11)  return {~p, BCD_12};
        else                   return {p, bcd_inc(h)};
    endfunction

endpackage

// File: rtl/al_bcd_counter.sv
// Packed-BCD two-digit counter with wrap range, increment enable and load.
module al_bcd_counter
    import al_pkg::*;
#(
    parameter logic [7:0] MIN_VAL = 8'h00,
    parameter logic [7:0] MAX_VAL = 8'h59,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] q,
    output logic [7:0] q_nxt,
    output logic       wrap
);

    // Next value: load wins over increment; wrap pulses on the MAX->MIN step.
    always_comb begin
        q_nxt = q;
        wrap  = 1'b0;
        if (load) begin
            q_nxt = load_val;
        end else if (inc) begin
            if (q == MAX_VAL) begin
                q_nxt = MIN_VAL;
                wrap  = 1'b1;
            end else begin
                q_nxt = bcd_inc(q);
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) q <= RST_VAL;
        else       q <= q_nxt;
    end

endmodule

// File: rtl/al_timekeeper.sv
// Time-of-day clock with set mode, alarm, snooze and ring timeout.
module al_timekeeper
    import al_pkg::*;
#(
    parameter int MODE_24H          = 1,
    parameter int SNOOZE_MIN        = 9,
    parameter int ALARM_TIMEOUT_MIN = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       set_mode,
    input  logic       inc_min,
    input  logic       inc_hr,
    input  logic       alarm_en,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    input  logic       alarm_pm,
    input  logic       snooze,
    input  logic       alarm_off,
    output logic [7:0] hh_bcd,
    output logic [7:0] mm_bcd,
    output logic [7:0] ss_bcd,
    output logic       pm,
    output logic       alarm_ring,
    output logic       snooze_pend
);

    localparam logic       IS_24H = (MODE_24H == AL_MODE_24H);
    localparam logic [7:0] HH_MIN = IS_24H ? BCD_00 : BCD_01;
    localparam logic [7:0] HH_MAX = IS_24H ? BCD_23 : BCD_12;
    localparam logic [7:0] HH_RST = IS_24H ? BCD_00 : BCD_12;
    localparam logic [6:0] SNZ    = 7'(clamp_rng(SNOOZE_MIN, SNOOZE_MIN_LO, SNOOZE_MIN_HI));
    localparam logic [5:0] TO_M1  = 6'(clamp_rng(ALARM_TIMEOUT_MIN, TIMEOUT_MIN_LO, TIMEOUT_MIN_HI) - 1);

    logic       tick, ss_wrap, mm_wrap, hh_wrap_unused;
    logic       mm_inc, hh_inc, pm_nxt;
    logic [7:0] ss_nxt, mm_nxt, hh_nxt;
    logic       alarm_hit, snz_hit;
    logic [6:0] snz_sum;
    logic       snz_c;
    logic [8:0] snz_hr;
    logic [7:0] tgt_hh, tgt_mm;
    logic       tgt_pm;
    logic [5:0] to_cnt;

    // Ticks only count in run mode; set-mode edits never carry into hours.
    assign tick   = sec_tick & ~set_mode;
    assign mm_inc = ss_wrap | (set_mode & inc_min);
    assign hh_inc = (mm_wrap & ~set_mode) | (set_mode & inc_hr);
    assign pm_nxt = IS_24H ? 1'b0 : (pm ^ (hh_inc && hh_bcd == BCD_11));

    al_bcd_counter #(.MIN_VAL(BCD_00), .MAX_VAL(BCD_59), .RST_VAL(BCD_00)) u_ss (
        .clk(clk), .reset(reset), .inc(tick), .load(set_mode), .load_val(BCD_00),
        .q(ss_bcd), .q_nxt(ss_nxt), .wrap(ss_wrap)
    );

    al_bcd_counter #(.MIN_VAL(BCD_00), .MAX_VAL(BCD_59), .RST_VAL(BCD_00)) u_mm (
        .clk(clk), .reset(reset), .inc(mm_inc), .load(1'b0), .load_val(BCD_00),
        .q(mm_bcd), .q_nxt(mm_nxt), .wrap(mm_wrap)
    );

    al_bcd_counter #(.MIN_VAL(HH_MIN), .MAX_VAL(HH_MAX), .RST_VAL(HH_RST)) u_hh (
        .clk(clk), .reset(reset), .inc(hh_inc), .load(1'b0), .load_val(BCD_00),
        .q(hh_bcd), .q_nxt(hh_nxt), .wrap(hh_wrap_unused)
    );

    // A tick that rolls seconds to 00 is the only way to land on hh:mm:00,
    // so set-mode edits can never raise a match.
    assign alarm_hit = alarm_en && ss_wrap && hh_nxt == alarm_hh && mm_nxt == alarm_mm &&
                       (IS_24H || pm_nxt == alarm_pm);
    assign snz_hit   = snooze_pend && ss_wrap && hh_nxt == tgt_hh && mm_nxt == tgt_mm &&
                       (IS_24H || pm_nxt == tgt_pm);

    // Snooze target: current hh:mm plus SNZ minutes, carrying into hour/pm.
    always_comb begin
        snz_sum = bcd2bin(mm_bcd) + SNZ;
        snz_c   = (snz_sum >= 7'd60);
        if (snz_c) snz_sum = snz_sum - 7'd60;
        snz_hr  = snz_c ? hr_inc(hh_bcd, pm, IS_24H) : {pm, hh_bcd};
    end

    // PM flag register.
    always_ff @(posedge clk) begin
        if (reset) pm <= 1'b0;
        else       pm <= pm_nxt;
    end

    // Alarm state: off/disable beats snooze, snooze beats match/timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_ring  <= 1'b0;
            snooze_pend <= 1'b0;
            to_cnt      <= '0;
            tgt_hh      <= '0;
            tgt_mm      <= '0;
            tgt_pm      <= 1'b0;
        end else if (alarm_off || !alarm_en) begin
            alarm_ring  <= 1'b0;
            snooze_pend <= 1'b0;
            to_cnt      <= '0;
        end else if (snooze && alarm_ring) begin
            alarm_ring  <= 1'b0;
            snooze_pend <= 1'b1;
            to_cnt      <= '0;
            tgt_hh      <= snz_hr[7:0];
            tgt_mm      <= bin2bcd(snz_sum);
            tgt_pm      <= snz_hr[8];
        end else if (alarm_hit || snz_hit) begin
            // A fresh match also restarts any timeout in progress.
            alarm_ring  <= 1'b1;
            to_cnt      <= '0;
            if (snz_hit) snooze_pend <= 1'b0;
        end else if (alarm_ring && ss_wrap) begin
            if (to_cnt == TO_M1) begin
                alarm_ring <= 1'b0;
                to_cnt     <= '0;
            end else begin
                to_cnt     <= to_cnt + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_al_timekeeper.sv
// Scoreboard bench: one 24h and one 12h instance driven by shared stimulus.
module tb_al_timekeeper;

    logic       clk = 1'b0;
    logic       reset = 1'b0, sec_tick = 1'b0, set_mode = 1'b0;
    logic       inc_min = 1'b0, inc_hr = 1'b0, alarm_en = 1'b0, alarm_pm = 1'b0;
    logic       snooze = 1'b0, alarm_off = 1'b0;
    logic [7:0] alarm_hh = 8'h00, alarm_mm = 8'h00;

    logic [7:0] hh24, mm24, ss24, hh12, mm12, ss12;
    logic       pm24, ring24, pend24, pm12, ring12, pend12;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        bit          inst;
        logic [26:0] val;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    al_timekeeper u_dut24 (
        .clk(clk), .reset(reset), .sec_tick(sec_tick), .set_mode(set_mode),
        .inc_min(inc_min), .inc_hr(inc_hr), .alarm_en(alarm_en), .alarm_hh(alarm_hh),
        .alarm_mm(alarm_mm), .alarm_pm(alarm_pm), .snooze(snooze), .alarm_off(alarm_off),
        .hh_bcd(hh24), .mm_bcd(mm24), .ss_bcd(ss24), .pm(pm24),
        .alarm_ring(ring24), .snooze_pend(pend24)
    );

    al_timekeeper #(.MODE_24H(0)) u_dut12 (
        .clk(clk), .reset(reset), .sec_tick(sec_tick), .set_mode(set_mode),
        .inc_min(inc_min), .inc_hr(inc_hr), .alarm_en(alarm_en), .alarm_hh(alarm_hh),
        .alarm_mm(alarm_mm), .alarm_pm(alarm_pm), .snooze(snooze), .alarm_off(alarm_off),
        .hh_bcd(hh12), .mm_bcd(mm12), .ss_bcd(ss12), .pm(pm12),
        .alarm_ring(ring12), .snooze_pend(pend12)
    );

    function automatic logic [26:0] pk(logic [7:0] h, logic [7:0] m, logic [7:0] s,
                                       logic p, logic r, logic n);
        return {h, m, s, p, r, n};
    endfunction

    function automatic logic [7:0] to_bcd(int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    // Reference time-of-day from a seconds-since-midnight count.
    function automatic logic [26:0] tod(int t, bit m24);
        int h24, h;
        h24 = t / 3600;
        if (m24) h = h24;
        else     h = (h24 % 12 == 0) ? 12 : h24 % 12;
        return pk(to_bcd(h), to_bcd((t / 60) % 60), to_bcd(t % 60),
                  m24 ? 1'b0 : (h24 >= 12), 1'b0, 1'b0);
    endfunction

    task automatic chk(string tag, logic [26:0] obs, logic [26:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp_v);
        end
    endtask

    task automatic exp1(string tag, logic [26:0] v);
        sb_q.push_back('{tag, 1'b0, v});
    endtask

    task automatic exp2(string tag, logic [26:0] v24, logic [26:0] v12);
        sb_q.push_back('{tag, 1'b0, v24});
        sb_q.push_back('{{tag, "_12h"}, 1'b1, v12});
    endtask

    // One clock; outputs sampled 1ns after the edge and checked against the queue.
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk(e.tag, e.inst ? {hh12, mm12, ss12, pm12, ring12, pend12}
                              : {hh24, mm24, ss24, pm24, ring24, pend24}, e.val);
        end
    endtask

    task automatic set_inc(int nh, int nm);
        for (int i = 0; i < ((nh > nm) ? nh : nm); i++) begin
            inc_hr  = (i < nh);
            inc_min = (i < nm);
            cyc();
        end
        inc_hr  = 1'b0;
        inc_min = 1'b0;
    endtask

    initial begin
        // Reset state.
        reset = 1'b1;
        exp2("reset", pk(8'h00, 8'h00, 8'h00, 0, 0, 0), pk(8'h12, 8'h00, 8'h00, 0, 0, 0));
        cyc();
        reset = 1'b0;

        // Full day walk; 12h instance crosses 11:59:59->12 pm and 12:59:59->01.
        sec_tick = 1'b1;
        for (int i = 1; i <= 86400; i++) begin
            exp2("walk", tod(i % 86400, 1'b1), tod(i % 86400, 1'b0));
            cyc();
        end

        repeat (4) cyc();
        exp2("tick5", pk(8'h00, 8'h00, 8'h05, 0, 0, 0), pk(8'h12, 8'h00, 8'h05, 0, 0, 0));
        cyc();

        // Set mode: ticks ignored, ss cleared on entry, inc_min wraps without carry.
        set_mode = 1'b1;
        for (int i = 0; i <= 60; i++) begin
            inc_hr  = (i < 3);
            inc_min = 1'b1;
            if (i == 0)
                exp2("set_entry", pk(8'h01, 8'h01, 8'h00, 0, 0, 0), pk(8'h01, 8'h01, 8'h00, 0, 0, 0));
            if (i == 60)
                exp2("set_3h61m", pk(8'h03, 8'h01, 8'h00, 0, 0, 0), pk(8'h03, 8'h01, 8'h00, 0, 0, 0));
            cyc();
        end
        inc_hr  = 1'b0;
        inc_min = 1'b0;

        // Alarm 07:30, set time up to it in set mode: no ring.
        alarm_hh = 8'h07;
        alarm_mm = 8'h30;
        alarm_en = 1'b1;
        set_inc(4, 28);
        exp1("set_0729", pk(8'h07, 8'h29, 8'h00, 0, 0, 0));
        cyc();
        set_inc(0, 1);
        exp1("set_no_match", pk(8'h07, 8'h30, 8'h00, 0, 0, 0));
        cyc();
        set_inc(0, 59);

        // Ring at 07:30:00, snooze, ring again at 07:39:00, disable clears.
        set_mode = 1'b0;
        sec_tick = 1'b1;
        repeat (58) cyc();
        exp1("pre_ring", pk(8'h07, 8'h29, 8'h59, 0, 0, 0));
        cyc();
        exp1("ring", pk(8'h07, 8'h30, 8'h00, 0, 1, 0));
        cyc();
        sec_tick = 1'b0;
        snooze   = 1'b1;
        exp1("snooze", pk(8'h07, 8'h30, 8'h00, 0, 0, 1));
        cyc();
        snooze   = 1'b0;
        sec_tick = 1'b1;
        repeat (539) cyc();
        exp1("snooze_ring", pk(8'h07, 8'h39, 8'h00, 0, 1, 0));
        cyc();
        sec_tick = 1'b0;
        alarm_en = 1'b0;
        exp1("en_low", pk(8'h07, 8'h39, 8'h00, 0, 0, 0));
        cyc();
        alarm_en = 1'b1;

        // Timeout after five minute carries.
        set_mode = 1'b1;
        set_inc(0, 50);
        exp1("set2", pk(8'h07, 8'h29, 8'h00, 0, 0, 0));
        cyc();
        set_mode = 1'b0;
        sec_tick = 1'b1;
        repeat (59) cyc();
        exp1("ring2", pk(8'h07, 8'h30, 8'h00, 0, 1, 0));
        cyc();
        repeat (298) cyc();
        exp1("to_hold", pk(8'h07, 8'h34, 8'h59, 0, 1, 0));
        cyc();
        exp1("timeout", pk(8'h07, 8'h35, 8'h00, 0, 0, 0));
        cyc();

        // alarm_off at 07:31, then snooze while silent is ignored.
        sec_tick = 1'b0;
        set_mode = 1'b1;
        set_inc(0, 54);
        exp1("set3", pk(8'h07, 8'h29, 8'h00, 0, 0, 0));
        cyc();
        set_mode = 1'b0;
        sec_tick = 1'b1;
        repeat (59) cyc();
        exp1("ring3", pk(8'h07, 8'h30, 8'h00, 0, 1, 0));
        cyc();
        repeat (59) cyc();
        exp1("ring3_0731", pk(8'h07, 8'h31, 8'h00, 0, 1, 0));
        cyc();
        sec_tick  = 1'b0;
        alarm_off = 1'b1;
        exp1("alarm_off", pk(8'h07, 8'h31, 8'h00, 0, 0, 0));
        cyc();
        alarm_off = 1'b0;
        snooze    = 1'b1;
        exp1("snooze_idle", pk(8'h07, 8'h31, 8'h00, 0, 0, 0));
        cyc();
        snooze    = 1'b0;

        // Reset together with snooze while ringing.
        set_mode = 1'b1;
        set_inc(0, 58);
        set_mode = 1'b0;
        sec_tick = 1'b1;
        repeat (59) cyc();
        exp1("ring4", pk(8'h07, 8'h30, 8'h00, 0, 1, 0));
        cyc();
        sec_tick = 1'b0;
        snooze   = 1'b1;
        reset    = 1'b1;
        exp2("reset_snz", pk(8'h00, 8'h00, 8'h00, 0, 0, 0), pk(8'h12, 8'h00, 8'h00, 0, 0, 0));
        cyc();
        snooze  = 1'b0;
        reset   = 1'b0;
        inc_min = 1'b1;
        inc_hr  = 1'b1;
        exp1("inc_run_ign", pk(8'h00, 8'h00, 8'h00, 0, 0, 0));
        cyc();
        inc_min  = 1'b0;
        inc_hr   = 1'b0;
        sec_tick = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            exp1("post_reset", pk(8'h00, 8'h00, to_bcd(k), 0, 0, 0));
            cyc();
        end
        sec_tick = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/al_timekeeper.md
AL_TIMEKEEPER -- requirements
Module: al_timekeeper

Interface
REQ-001 Parameter MODE_24H, default 1, selects 24-hour (1) or 12-hour (0) display counting.
REQ-002 Parameter SNOOZE_MIN, default 9, sets minutes added per snooze, legal range 1..59.
REQ-003 Parameter ALARM_TIMEOUT_MIN, default 5, sets minutes after which a ringing alarm self-clears, legal range 1..59.
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sec_tick  in  1  one-clk pulse per second; an enable, never a clock.
REQ-007 set_mode  in  1  level; high = time-set mode.
REQ-008 inc_min  in  1  one-clk pulse; advances minutes in set mode.
REQ-009 inc_hr  in  1  one-clk pulse; advances hours in set mode.
REQ-010 alarm_en  in  1  level; arms alarm compare.
REQ-011 alarm_hh  in  8  alarm hour, packed BCD, in current hour format.
REQ-012 alarm_mm  in  8  alarm minute, packed BCD 00..59.
REQ-013 alarm_pm  in  1  alarm PM flag; ignored when MODE_24H=1.
REQ-014 snooze  in  1  one-clk pulse; snooze a ringing alarm.
REQ-015 alarm_off  in  1  one-clk pulse; silence alarm and cancel snooze.
REQ-016 hh_bcd  out  8  current hour, packed BCD.
REQ-017 mm_bcd  out  8  current minute, packed BCD.
REQ-018 ss_bcd  out  8  current second, packed BCD.
REQ-019 pm  out  1  PM flag; constant 0 when MODE_24H=1.
REQ-020 alarm_ring  out  1  registered; high while alarm sounds.
REQ-021 snooze_pend  out  1  registered; high while a snooze target is armed.

Function
REQ-022 All outputs shall be registered; a counter change from a tick shall be visible the clk after the tick.
REQ-023 With set_mode low, each sec_tick shall increment ss in BCD 00..59; 59 shall wrap to 00 and carry to mm.
REQ-024 mm shall count 00..59; a 59 wrap shall carry to hh in the same clk.
REQ-025 MODE_24H=1: hh shall count 00..23, 23 wraps to 00.
REQ-026 MODE_24H=0: hh sequence 12,01..11,12; the 11->12 step toggles pm; 12->01 does not.
REQ-027 With set_mode high, sec_tick shall be ignored and ss held at 00; ss shall load 00 on the clk set_mode rises.
REQ-028 In set mode inc_min shall advance mm with wrap but no carry into hh; inc_hr shall advance hh per REQ-025/026, toggling pm as there.
REQ-029 inc_min and inc_hr in the same clk shall both apply; both shall be ignored when set_mode is low.
REQ-030 Alarm match: on the clk a tick makes hh:mm:ss equal alarm_hh:alarm_mm:00 (and pm==alarm_pm in 12h), with alarm_en high, alarm_ring shall set.
REQ-031 Time entered via set mode shall never trigger a match.
REQ-032 snooze while alarm_ring high shall clear alarm_ring, set snooze_pend, and store target = current hh:mm + SNOOZE_MIN with hour/pm carry; snooze with alarm_ring low is ignored.
REQ-033 When a tick reaches target hh:mm:00 with snooze_pend high, alarm_ring shall set and snooze_pend clear.
REQ-034 alarm_ring shall clear automatically ALARM_TIMEOUT_MIN minute carries after setting.
REQ-035 alarm_off, or alarm_en low, shall clear alarm_ring and snooze_pend next clk.
REQ-036 Priority, high to low: reset, alarm_off/alarm_en low, snooze, match/timeout.
REQ-037 A match and timeout in the same clk shall leave alarm_ring set and restart the timeout count.

Reset
REQ-038 reset shall, on the next clk edge, force: hh=00 (24h) or 12 (12h), mm=00, ss=00, pm=0, alarm_ring=0, snooze_pend=0, timeout count=0, snooze target=0.
REQ-039 reset asserted mid-ring or mid-snooze shall discard all alarm state with no trailing pulse.

Structure
REQ-040 Shared package al_pkg shall hold BCD limit constants (59, 23, 12, 11), the 12/24 mode encoding and the snooze/timeout range limits.
REQ-041 One sub-module al_bcd_counter (packed-BCD pair, parameterised min/max, inc enable, synchronous load, wrap/carry pulse) shall be instantiated for ss, mm and hh.
REQ-042 Expected size is 120-400 RTL lines across both modules.

Verification
REQ-043 reset, 24h, 86400 ticks -> hh:mm:ss walks 00:00:00..23:59:59 and returns to 00:00:00, all digits BCD-legal.
REQ-044 12h, from 11:59:59 pm=0, one tick -> 12:00:00 pm=1; run to 12:59:59, one tick -> 01:00:00 pm=1.
REQ-045 set_mode high, 3 inc_hr + 61 inc_min, ticks applied -> hh=03, mm=01, ss=00 unchanged by ticks.
REQ-046 Alarm 07:30, alarm_en=1, run from 07:29:58 -> alarm_ring high after tick to 07:30:00; snooze -> ring low, snooze_pend high; ring again at 07:39:00.
REQ-047 Ring at 07:30:00, no action -> ring clears at 07:35:00; repeat with alarm_off at 07:31 -> ring low next clk, snooze_pend 0.
REQ-048 reset pulsed same clk as snooze while ringing -> all outputs at reset values next clk, no later ring.
